// File: rtl/cpu_pkg.sv
// Shared definitions for the register-bank write-back path: source codes,
// the write request layout and the write-back arbiter state encoding.
package cpu_pkg;

  localparam logic [2:0] SRC_CONST227 = 3'd0;
  localparam logic [2:0] SRC_D1       = 3'd1;
  localparam logic [2:0] SRC_D2       = 3'd2;
  localparam logic [2:0] SRC_D3       = 3'd3;
  localparam logic [2:0] SRC_D4       = 3'd4;
  localparam logic [2:0] SRC_D5       = 3'd5;
  localparam logic [2:0] SRC_D6       = 3'd6;
  localparam logic [2:0] SRC_ILLEGAL  = 3'd7;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic [2:0] src;
    logic [4:0] dst;
  } wb_req_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_HELD  = 1'b1
  } wb_state_e;

  // A source code is legal when it selects one of the first n_src mux inputs.
  function automatic logic src_legal(logic [2:0] src, int n_src);
    return int'(src) < n_src;
  endfunction

endpackage

// File: rtl/wb_sequencer_if.sv
// Request/response bundle between the write-back requesters, the register
// bank and the write-back sequencer.
interface wb_sequencer_if;
  import cpu_pkg::*;

  logic       a_valid;
  logic [2:0] a_src;
  logic [4:0] a_dst;
  logic       a_ready;
  logic       b_valid;
  logic [2:0] b_src;
  logic [4:0] b_dst;
  logic       b_ready;
  logic [2:0] wb_sel;
  logic       wb_we;
  logic [4:0] wb_addr;
  logic       pend_valid;
  logic [4:0] pend_dst;
  logic       err_illegal;

  // Requester / observer side.
  modport master (
    output a_valid, a_src, a_dst, b_valid, b_src, b_dst,
    input  a_ready, b_ready, wb_sel, wb_we, wb_addr, pend_valid, pend_dst, err_illegal
  );

  // Sequencer side.
  modport slave (
    input  a_valid, a_src, a_dst, b_valid, b_src, b_dst,
    output a_ready, b_ready, wb_sel, wb_we, wb_addr, pend_valid, pend_dst, err_illegal
  );

endinterface

// File: rtl/wb_hold_buf.sv
// Single-entry holding buffer for a deferred port A request, plus the
// saturating count of cycles it has lost arbitration to port B.
module wb_hold_buf
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 2
) (
  input  logic    clk,
  input  logic    reset,
  input  logic    capture,
  input  wb_req_t capture_req,
  input  logic    bump,
  output wb_req_t held_req,
  output logic    cnt_at_max
);

  localparam int CW = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;

  wb_req_t       req_q, req_d;
  logic [CW-1:0] cnt_q, cnt_d;

  assign held_req   = req_q;
  assign cnt_at_max = (cnt_q == CW'(MAX_WAIT));

  // Capture restarts the wait count; bumps saturate so the counter never wraps.
  always_comb begin
    req_d = req_q;
    cnt_d = cnt_q;
    if (capture) begin
      req_d = capture_req;
      cnt_d = '0;
    end else if (bump && !cnt_at_max) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Buffer and counter registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_q <= '0;
      cnt_q <= '0;
    end else begin
      req_q <= req_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_sequencer.sv
// Write-back scheduler for the register bank: arbitrates the control FSM
// (port A) against late-result units (port B) onto the single write port.
//
//   state    | meaning
//   ---------+------------------------------------------------------------
//   ST_EMPTY | no deferred A request; A is accepted, B wins any collision
//   ST_HELD  | one A request buffered; B may pass it at most MAX_WAIT times
module wb_sequencer
  import cpu_pkg::*;
#(
  parameter int MAX_WAIT = 2,
  parameter int N_SRC    = 7
) (
  input  logic            clk,
  input  logic            reset,
  wb_sequencer_if.slave   bus
);

  wb_state_e  state_q, state_d;
  logic [2:0] wb_sel_q, wb_sel_d;
  logic [4:0] wb_addr_q, wb_addr_d;
  logic       wb_we_q, wb_we_d;
  logic       err_q, err_d;

  logic       issue;
  wb_req_t    issue_req;
  logic       capture;
  logic       bump;
  wb_req_t    a_req, b_req, held_req;
  logic       cnt_at_max;

  assign a_req = '{src: bus.a_src, dst: bus.a_dst};
  assign b_req = '{src: bus.b_src, dst: bus.b_dst};

  wb_hold_buf #(.MAX_WAIT(MAX_WAIT)) u_hold_buf (
    .clk         (clk),
    .reset       (reset),
    .capture     (capture),
    .capture_req (a_req),
    .bump        (bump),
    .held_req    (held_req),
    .cnt_at_max  (cnt_at_max)
  );

  assign bus.a_ready     = (state_q == ST_EMPTY);
  assign bus.b_ready     = 1'b1;
  assign bus.pend_valid  = (state_q == ST_HELD);
  assign bus.pend_dst    = held_req.dst;
  assign bus.wb_sel      = wb_sel_q;
  assign bus.wb_we       = wb_we_q;
  assign bus.wb_addr     = wb_addr_q;
  assign bus.err_illegal = err_q;

  // Arbitration, then translation of the chosen request into write-port values.
  always_comb begin
    state_d   = state_q;
    issue     = 1'b0;
    issue_req = '0;
    capture   = 1'b0;
    bump      = 1'b0;
    err_d     = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (bus.b_valid) begin
          issue     = 1'b1;
          issue_req = b_req;
          if (bus.a_valid) begin
            // An illegal A is dropped here rather than parked in the buffer.
            if (src_legal(bus.a_src, N_SRC)) begin
              capture = 1'b1;
              state_d = ST_HELD;
            end else begin
              err_d = 1'b1;
            end
          end
        end else if (bus.a_valid) begin
          issue     = 1'b1;
          issue_req = a_req;
        end
      end
      ST_HELD: begin
        if (bus.b_valid && !cnt_at_max) begin
          issue     = 1'b1;
          issue_req = b_req;
          bump      = 1'b1;
        end else begin
          // Forced or free slot: the held A goes out; a concurrent B is
          // acknowledged but lost and must be resent by its owner.
          issue     = 1'b1;
          issue_req = held_req;
          state_d   = ST_EMPTY;
        end
      end
      default: state_d = ST_EMPTY;
    endcase

    wb_we_d   = 1'b0;
    wb_sel_d  = wb_sel_q;
    wb_addr_d = wb_addr_q;
    if (issue) begin
      if (!src_legal(issue_req.src, N_SRC)) begin
        err_d = 1'b1;
      end else begin
        wb_sel_d  = issue_req.src;
        wb_addr_d = issue_req.dst;
        wb_we_d   = (issue_req.dst != REG_ZERO);
      end
    end
  end

  // State and registered write-port outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_EMPTY;
      wb_sel_q  <= '0;
      wb_addr_q <= '0;
      wb_we_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_sel_q  <= wb_sel_d;
      wb_addr_q <= wb_addr_d;
      wb_we_q   <= wb_we_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Self-checking bench for wb_sequencer: a scoreboard of expected write-port
// values per cycle plus inline checks of handshake and buffer status.
module tb_wb_sequencer;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;

  typedef struct {
    int         cyc;
    logic       we;
    logic       chk;
    logic [2:0] sel;
    logic [4:0] addr;
    logic       err;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  wb_sequencer_if bus ();

  wb_sequencer #(.MAX_WAIT(2), .N_SRC(7)) dut (
    .clk   (clk),
    .reset (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard consumer: compare write-port outputs mid-cycle.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      mon_e = sb.pop_front();
      n_checks++;
      if (mon_e.cyc != cyc) begin
        $display("FAIL sb_stale: entry for cycle %0d seen at cycle %0d", mon_e.cyc, cyc);
      end else if (bus.wb_we !== mon_e.we || bus.err_illegal !== mon_e.err ||
                   (mon_e.chk && (bus.wb_sel !== mon_e.sel || bus.wb_addr !== mon_e.addr))) begin
        $display("FAIL sb_write cyc %0d: got we=%b sel=%0d addr=%0d err=%b, want we=%b sel=%0d addr=%0d err=%b (sel/addr checked=%b)",
                 cyc, bus.wb_we, bus.wb_sel, bus.wb_addr, bus.err_illegal,
                 mon_e.we, mon_e.sel, mon_e.addr, mon_e.err, mon_e.chk);
      end else begin
        n_pass++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic av, logic [2:0] as_, logic [4:0] ad,
                       logic bv, logic [2:0] bs, logic [4:0] bd);
    bus.a_valid = av;
    bus.a_src   = as_;
    bus.a_dst   = ad;
    bus.b_valid = bv;
    bus.b_src   = bs;
    bus.b_dst   = bd;
  endtask

  // Expectation for the cycle following the next rising edge.
  task automatic push(logic we, logic chk, logic [2:0] sel, logic [4:0] addr, logic err);
    exp_t e;
    e.cyc  = cyc + 1;
    e.we   = we;
    e.chk  = chk;
    e.sel  = sel;
    e.addr = addr;
    e.err  = err;
    sb.push_back(e);
  endtask

  task automatic test_reset();
    // Initial reset state.
    n_checks++;
    if ({bus.wb_sel, bus.wb_we, bus.wb_addr, bus.pend_valid, bus.pend_dst, bus.err_illegal} !== 15'd0) begin
      $display("FAIL reset_init: got sel=%0d we=%b addr=%0d pv=%b pd=%0d err=%b, want all 0",
               bus.wb_sel, bus.wb_we, bus.wb_addr, bus.pend_valid, bus.pend_dst, bus.err_illegal);
    end else n_pass++;
    #9 rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.wb_we !== 1'b0) $display("FAIL reset_release_we: got %b want 0", bus.wb_we);
    else n_pass++;

    // Reset asserted while a write is on the port.
    drive(1, 3'd3, 5'd8, 0, 3'd0, 5'd0);
    tick();
    n_checks++;
    if (bus.wb_we !== 1'b1 || bus.wb_sel !== 3'd3 || bus.wb_addr !== 5'd8)
      $display("FAIL reset_prewrite: got we=%b sel=%0d addr=%0d want we=1 sel=3 addr=8",
               bus.wb_we, bus.wb_sel, bus.wb_addr);
    else n_pass++;
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({bus.wb_sel, bus.wb_we, bus.wb_addr, bus.pend_valid, bus.pend_dst, bus.err_illegal} !== 15'd0)
      $display("FAIL reset_async: got sel=%0d we=%b addr=%0d pv=%b pd=%0d err=%b, want all 0",
               bus.wb_sel, bus.wb_we, bus.wb_addr, bus.pend_valid, bus.pend_dst, bus.err_illegal);
    else n_pass++;
    #1 rst_n = 1'b1;
    tick();
    n_checks++;
    if (bus.wb_we !== 1'b0) $display("FAIL reset_post_we: got %b want 0", bus.wb_we);
    else n_pass++;
  endtask

  task automatic test_a_only();
    n_checks++;
    if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1)
      $display("FAIL a_only_ready: got a_ready=%b b_ready=%b want 1/1", bus.a_ready, bus.b_ready);
    else n_pass++;
    drive(1, 3'd3, 5'd8, 0, 3'd0, 5'd0);
    push(1, 1, 3'd3, 5'd8, 0);
    tick();
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    push(0, 1, 3'd3, 5'd8, 0);
    tick();
  endtask

  task automatic test_simultaneous();
    drive(1, 3'd1, 5'd5, 1, 3'd5, 5'd9);
    push(1, 1, 3'd5, 5'd9, 0);
    tick();
    n_checks++;
    if (bus.pend_valid !== 1'b1 || bus.pend_dst !== 5'd5 || bus.a_ready !== 1'b0)
      $display("FAIL simul_held: got pv=%b pd=%0d a_ready=%b want pv=1 pd=5 a_ready=0",
               bus.pend_valid, bus.pend_dst, bus.a_ready);
    else n_pass++;
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    push(1, 1, 3'd1, 5'd5, 0);
    tick();
    n_checks++;
    if (bus.pend_valid !== 1'b0 || bus.a_ready !== 1'b1)
      $display("FAIL simul_drain: got pv=%b a_ready=%b want pv=0 a_ready=1", bus.pend_valid, bus.a_ready);
    else n_pass++;
    push(0, 0, 3'd0, 5'd0, 0);
    tick();
  endtask

  task automatic test_starvation();
    drive(1, 3'd4, 5'd10, 1, 3'd1, 5'd11);
    push(1, 1, 3'd1, 5'd11, 0);
    tick();
    n_checks++;
    if (bus.pend_valid !== 1'b1 || bus.pend_dst !== 5'd10)
      $display("FAIL starve_held: got pv=%b pd=%0d want pv=1 pd=10", bus.pend_valid, bus.pend_dst);
    else n_pass++;
    drive(0, 3'd0, 5'd0, 1, 3'd2, 5'd12);
    push(1, 1, 3'd2, 5'd12, 0);
    tick();
    drive(0, 3'd0, 5'd0, 1, 3'd3, 5'd13);
    push(1, 1, 3'd3, 5'd13, 0);
    tick();
    drive(0, 3'd0, 5'd0, 1, 3'd5, 5'd14);
    push(1, 1, 3'd4, 5'd10, 0);
    n_checks++;
    if (bus.b_ready !== 1'b1) $display("FAIL starve_b_ready: got %b want 1", bus.b_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (bus.pend_valid !== 1'b0)
      $display("FAIL starve_forced: got pv=%b want 0", bus.pend_valid);
    else n_pass++;
    push(1, 1, 3'd5, 5'd14, 0);
    tick();
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    push(0, 1, 3'd5, 5'd14, 0);
    tick();
  endtask

  task automatic test_zero_reg();
    drive(1, 3'd2, 5'd0, 0, 3'd0, 5'd0);
    push(0, 1, 3'd2, 5'd0, 0);
    tick();
    n_checks++;
    if (bus.a_ready !== 1'b1) $display("FAIL zero_a_ready: got %b want 1", bus.a_ready);
    else n_pass++;
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    push(0, 0, 3'd0, 5'd0, 0);
    tick();
  endtask

  task automatic test_illegal();
    drive(0, 3'd0, 5'd0, 1, 3'd7, 5'd4);
    push(0, 0, 3'd0, 5'd0, 1);
    tick();
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    push(0, 0, 3'd0, 5'd0, 0);
    tick();
    drive(1, 3'd7, 5'd6, 1, 3'd6, 5'd7);
    push(1, 1, 3'd6, 5'd7, 1);
    tick();
    n_checks++;
    if (bus.pend_valid !== 1'b0 || bus.a_ready !== 1'b1)
      $display("FAIL illegal_a_capture: got pv=%b a_ready=%b want pv=0 a_ready=1", bus.pend_valid, bus.a_ready);
    else n_pass++;
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    push(0, 0, 3'd0, 5'd0, 0);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [2:0] s;
    logic [4:0] d;
    for (int i = 0; i < 6; i++) begin
      s = 3'($urandom_range(1, 6));
      d = 5'($urandom_range(1, 31));
      drive(1, s, d, 0, 3'd0, 5'd0);
      push(1, 1, s, d, 0);
      tick();
    end
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    push(0, 0, 3'd0, 5'd0, 0);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    drive(0, 3'd0, 5'd0, 0, 3'd0, 5'd0);
    #3;
    test_reset();
    test_a_only();
    test_simultaneous();
    test_starvation();
    test_zero_reg();
    test_illegal();
    test_back_to_back();
    for (int i = 0; i < 10 && sb.size() > 0; i++) tick();
    if (sb.size() > 0) begin
      n_checks++;
      $display("FAIL sb_drain: %0d expectations left, want 0", sb.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
